// File: rtl/summ_norm_acc.sv
// summ_norm_acc: sums LENGTH sign-magnitude terms per frame and emits a normalised result with guard bits.
// Optional macro SUMM_NORM_ACC_SAT_EN clamps the magnitude on overflow instead of wrapping.
module summ_norm_acc #(
  parameter int DEMENTION = 8,
  parameter int GUARD     = 4,
  parameter int LENGTH    = 16
) (
  input  logic                       iClk,
  input  logic                       iRst,
  input  logic                       iClear,
  input  logic [DEMENTION-1:0]       iData,
  input  logic                       iValid,
  output logic                       oReady,
  output logic [DEMENTION-1+GUARD:0] oResult,
  output logic                       oValid,
  input  logic                       iReady,
  output logic                       oOverflow
);

  localparam int M  = DEMENTION - 1 + GUARD;
  localparam int CW = (LENGTH > 1) ? $clog2(LENGTH) : 1;

  typedef enum logic {ACC, OUT} state_t;

  state_t         r_state;
  logic [M-1:0]   r_accMag;
  logic           r_accSign;
  logic [CW-1:0]  r_count;
  logic           r_sticky;
  logic [M:0]     r_result;
  logic           r_valid;
  logic           r_overflow;

  logic [M-1:0]   w_termMag;
  logic           w_termSign;
  logic [M:0]     w_sameSum;
  logic [M-1:0]   w_nextMag;
  logic           w_nextSign;
  logic           w_carry;
  logic           w_lastTerm;

  // A zero-magnitude input is always treated as +0, whatever its sign bit says.
  always_comb begin
    w_termMag                  = '0;
    w_termMag[DEMENTION-2:0]   = iData[DEMENTION-2:0];
    w_termSign                 = iData[DEMENTION-1] & (|iData[DEMENTION-2:0]);
  end

  assign w_sameSum = {1'b0, r_accMag} + {1'b0, w_termMag};

  always_comb begin
    w_carry    = 1'b0;
    w_nextMag  = '0;
    w_nextSign = 1'b0;
    if (r_accSign == w_termSign) begin
      w_carry    = w_sameSum[M];
      w_nextSign = r_accSign;
`ifdef SUMM_NORM_ACC_SAT_EN
      w_nextMag  = w_sameSum[M] ? {M{1'b1}} : w_sameSum[M-1:0];
`else
      w_nextMag  = w_sameSum[M-1:0];
`endif
    end else if (r_accMag >= w_termMag) begin
      w_nextMag  = r_accMag - w_termMag;
      w_nextSign = r_accSign;
    end else begin
      w_nextMag  = w_termMag - r_accMag;
      w_nextSign = w_termSign;
    end
    if (w_nextMag == '0) begin
      w_nextSign = 1'b0;
    end
  end

  assign w_lastTerm = (r_count == CW'(LENGTH - 1));

  // Priority is reset, then clear, then the normal accept/handshake flow.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state    <= ACC;
      r_accMag   <= '0;
      r_accSign  <= 1'b0;
      r_count    <= '0;
      r_sticky   <= 1'b0;
      r_result   <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (iClear) begin
      r_state    <= ACC;
      r_accMag   <= '0;
      r_accSign  <= 1'b0;
      r_count    <= '0;
      r_sticky   <= 1'b0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        ACC: begin
          if (iValid) begin
            if (w_lastTerm) begin
              r_result   <= {w_nextSign, w_nextMag};
              r_overflow <= r_sticky | w_carry;
              r_valid    <= 1'b1;
              r_state    <= OUT;
              r_accMag   <= '0;
              r_accSign  <= 1'b0;
              r_count    <= '0;
              r_sticky   <= 1'b0;
            end else begin
              r_accMag   <= w_nextMag;
              r_accSign  <= w_nextSign;
              r_count    <= r_count + CW'(1);
              r_sticky   <= r_sticky | w_carry;
            end
          end
        end
        OUT: begin
          if (iReady) begin
            r_state    <= ACC;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
          end
        end
        default: r_state <= ACC;
      endcase
    end
  end

  assign oReady    = (r_state == ACC) && !iRst;
  assign oResult   = r_result;
  assign oValid    = r_valid;
  assign oOverflow = r_overflow;

endmodule
